// File: rtl/gf256_inv_sbox_pipe_if.sv
// Stream bundle for gf256_inv_sbox_pipe: input beat handshake, result handshake and busy.
// With GF256_SBOX_FWD_MODE_EN defined, a per-beat fwd select travels with in_data.
interface gf256_inv_sbox_pipe_if #(
    parameter int unsigned LANES = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [8*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [8*LANES-1:0]   out_data;
    logic                 busy;
`ifdef GF256_SBOX_FWD_MODE_EN
    logic                 fwd;
`endif

    modport master (
`ifdef GF256_SBOX_FWD_MODE_EN
        output fwd,
`endif
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
`ifdef GF256_SBOX_FWD_MODE_EN
        input  fwd,
`endif
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/gf256_inv_sbox_pipe.sv
// 3-stage AES InvSubBytes engine on a tower-field GF(((2^2)^2)^2) inverter, LANES bytes per beat.
// Optional forward S-box per beat when GF256_SBOX_FWD_MODE_EN is defined.
module gf256_inv_sbox_pipe #(
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    gf256_inv_sbox_pipe_if.slave  bus
);
    // GF(4): poly basis, w^2 = w + 1
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic hh;
        hh = a[1] & b[1];
        return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
    endfunction

    // GF(16) over GF(4): poly basis, z^2 = z + w
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul(hh, 2'b10) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] d, di;
        d  = gf4_mul(gf4_mul(a[3:2], a[3:2]), 2'b10) ^ gf4_mul(a[3:2], a[1:0])
           ^ gf4_mul(a[1:0], a[1:0]);
        di = {d[1], d[1] ^ d[0]};
        return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
    endfunction

    function automatic logic [3:0] gf16_sq_scl(input logic [3:0] x, input logic [3:0] nu);
        return gf16_mul(gf16_mul(x, x), nu);
    endfunction

    // GF(256) over GF(16): normal basis {Y, Y^16}, byte = {hi, lo} = hi*Y + lo*Y^16
    function automatic logic [7:0] twr_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] nu);
        logic [3:0] e;
        e = gf16_mul(gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), nu);
        return {gf16_mul(a[7:4], b[7:4]) ^ e, gf16_mul(a[3:0], b[3:0]) ^ e};
    endfunction

    // nu must make Y^2 + Y + nu irreducible over GF(16): no root r with r^2 + r = nu
    function automatic logic [3:0] find_nu();
        logic [3:0] nu;
        logic       hit, found;
        nu = '0;
        found = 1'b0;
        for (int unsigned c = 1; c < 16; c++) begin
            hit = 1'b0;
            for (int unsigned r = 0; r < 16; r++)
                if ((gf16_mul(4'(r), 4'(r)) ^ 4'(r)) == 4'(c)) hit = 1'b1;
            if (!found && !hit) begin
                nu = 4'(c);
                found = 1'b1;
            end
        end
        return nu;
    endfunction

    // Tower image of the AES generator: a root of x^8 + x^4 + x^3 + x + 1 (tower one = 8'h11)
    function automatic logic [7:0] find_beta(input logic [3:0] nu);
        logic [7:0] x, x2, x3, x4, x8, beta;
        logic       found;
        beta = '0;
        found = 1'b0;
        for (int unsigned b = 1; b < 256; b++) begin
            x  = 8'(b);
            x2 = twr_mul(x, x, nu);
            x3 = twr_mul(x2, x, nu);
            x4 = twr_mul(x2, x2, nu);
            x8 = twr_mul(x4, x4, nu);
            if (!found && ((x8 ^ x4 ^ x3 ^ x ^ 8'h11) == 8'h00)) begin
                beta = x;
                found = 1'b1;
            end
        end
        return beta;
    endfunction

    // Row r of the AES->tower matrix holds bit r of beta^0 .. beta^7
    function automatic logic [7:0][7:0] twr_rows(input logic [3:0] nu, input logic [7:0] beta);
        logic [7:0][7:0] m;
        logic [7:0]      p;
        m = '0;
        p = 8'h11;
        for (int unsigned i = 0; i < 8; i++) begin
            for (int unsigned r = 0; r < 8; r++) m[3'(r)][3'(i)] = p[3'(r)];
            p = twr_mul(p, beta, nu);
        end
        return m;
    endfunction

    function automatic logic [7:0][7:0] mat_inv(input logic [7:0][7:0] m);
        logic [7:0][7:0] a, b;
        logic [7:0]      t;
        logic            found;
        a = m;
        for (int unsigned r = 0; r < 8; r++) b[3'(r)] = 8'h01 << r;
        for (int unsigned c = 0; c < 8; c++) begin
            found = 1'b0;
            for (int unsigned p = c; p < 8; p++) begin
                if (!found && a[3'(p)][3'(c)]) begin
                    t = a[3'(c)]; a[3'(c)] = a[3'(p)]; a[3'(p)] = t;
                    t = b[3'(c)]; b[3'(c)] = b[3'(p)]; b[3'(p)] = t;
                    found = 1'b1;
                end
            end
            for (int unsigned r = 0; r < 8; r++) begin
                if (r != c && a[3'(r)][3'(c)]) begin
                    a[3'(r)] = a[3'(r)] ^ a[3'(c)];
                    b[3'(r)] = b[3'(r)] ^ b[3'(c)];
                end
            end
        end
        return b;
    endfunction

    function automatic logic [7:0] basis_map(input logic [7:0][7:0] rows, input logic [7:0] x);
        logic [7:0] y;
        for (int unsigned r = 0; r < 8; r++) y[3'(r)] = ^(rows[3'(r)] & x);
        return y;
    endfunction

    function automatic logic [7:0] inv_affine_lin(input logic [7:0] x);
        logic [7:0] y;
        for (int unsigned i = 0; i < 8; i++)
            y[3'(i)] = x[3'(i + 2)] ^ x[3'(i + 5)] ^ x[3'(i + 7)];
        return y;
    endfunction

`ifdef GF256_SBOX_FWD_MODE_EN
    function automatic logic [7:0] fwd_affine_lin(input logic [7:0] x);
        logic [7:0] y;
        for (int unsigned i = 0; i < 8; i++)
            y[3'(i)] = x[3'(i)] ^ x[3'(i + 4)] ^ x[3'(i + 5)] ^ x[3'(i + 6)] ^ x[3'(i + 7)];
        return y;
    endfunction
`endif

    // Basis matrices are derived at elaboration from the chosen tower, so they stay consistent with it
    localparam logic [3:0]      NU        = find_nu();
    localparam logic [7:0]      BETA      = find_beta(NU);
    localparam logic [7:0][7:0] TO_TWR    = twr_rows(NU, BETA);
    localparam logic [7:0][7:0] FROM_TWR  = mat_inv(TO_TWR);

    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [8*LANES-1:0]   s1_q, s1_d, s3_q, s3_d;
    logic [4*LANES-1:0]   s2_hi_q, s2_hi_d, s2_lo_q, s2_lo_d, s2_dinv_q, s2_dinv_d;
`ifdef GF256_SBOX_FWD_MODE_EN
    logic                 fwd1_q, fwd1_d, fwd2_q, fwd2_d;
`endif
    logic                 adv1, adv2, adv3, in_fire;
    logic [7:0]           a, b;
    logic [3:0]           hi, lo, d, dinv;

    always_comb begin
        adv3 = !v3_q || bus.out_ready;
        adv2 = !v2_q || adv3;
        adv1 = !v1_q || adv2;
        in_fire = bus.in_valid && adv1 && !rst;

        v1_d = v1_q; v2_d = v2_q; v3_d = v3_q;
        s1_d = s1_q; s3_d = s3_q;
        s2_hi_d = s2_hi_q; s2_lo_d = s2_lo_q; s2_dinv_d = s2_dinv_q;
`ifdef GF256_SBOX_FWD_MODE_EN
        fwd1_d = fwd1_q; fwd2_d = fwd2_q;
`endif
        a = '0; b = '0; hi = '0; lo = '0; d = '0; dinv = '0;

        if (adv1) v1_d = bus.in_valid;
        if (in_fire) begin
`ifdef GF256_SBOX_FWD_MODE_EN
            fwd1_d = bus.fwd;
`endif
            for (int unsigned l = 0; l < LANES; l++) begin
                b = bus.in_data[8*l +: 8];
                a = inv_affine_lin(b ^ 8'h63);
`ifdef GF256_SBOX_FWD_MODE_EN
                if (bus.fwd) a = b;
`endif
                s1_d[8*l +: 8] = basis_map(TO_TWR, a);
            end
        end

        if (adv2) v2_d = v1_q;
        if (adv2 && v1_q) begin
`ifdef GF256_SBOX_FWD_MODE_EN
            fwd2_d = fwd1_q;
`endif
            for (int unsigned l = 0; l < LANES; l++) begin
                hi = s1_q[8*l + 4 +: 4];
                lo = s1_q[8*l +: 4];
                d  = gf16_sq_scl(hi ^ lo, NU) ^ gf16_mul(hi, lo);
                s2_hi_d[4*l +: 4]   = hi;
                s2_lo_d[4*l +: 4]   = lo;
                s2_dinv_d[4*l +: 4] = gf16_inv(d);
            end
        end

        if (adv3) v3_d = v2_q;
        if (adv3 && v2_q) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                hi   = s2_hi_q[4*l +: 4];
                lo   = s2_lo_q[4*l +: 4];
                dinv = s2_dinv_q[4*l +: 4];
                a = basis_map(FROM_TWR, {gf16_mul(lo, dinv), gf16_mul(hi, dinv)});
`ifdef GF256_SBOX_FWD_MODE_EN
                if (fwd2_q) a = fwd_affine_lin(a) ^ 8'h63;
`endif
                s3_d[8*l +: 8] = a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            s1_q <= '0; s3_q <= '0;
            s2_hi_q <= '0; s2_lo_q <= '0; s2_dinv_q <= '0;
`ifdef GF256_SBOX_FWD_MODE_EN
            fwd1_q <= 1'b0; fwd2_q <= 1'b0;
`endif
        end else begin
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
            s1_q <= s1_d; s3_q <= s3_d;
            s2_hi_q <= s2_hi_d; s2_lo_q <= s2_lo_d; s2_dinv_q <= s2_dinv_d;
`ifdef GF256_SBOX_FWD_MODE_EN
            fwd1_q <= fwd1_d; fwd2_q <= fwd2_d;
`endif
        end
    end

    assign bus.in_ready  = adv1 && !rst;
    assign bus.out_valid = v3_q;
    assign bus.out_data  = s3_q;
    assign bus.busy      = v1_q | v2_q | v3_q;
endmodule
